// File: rtl/ibuff_pkg.sv
// rtl/ibuff_pkg.sv - shared defaults, pointer/count types and popcount for the instruction buffer
package ibuff_pkg;

   localparam int DEPTH    = 32;
   localparam int INDEX    = 5;
   localparam int WR_PORTS = 8;
   localparam int RD_PORTS = 4;

   typedef logic [INDEX-1:0] ibuffPtr_t;
   typedef logic [INDEX:0]   ibuffCnt_t;

   function automatic int unsigned popcount(input logic [63:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 64; i++) begin
         n = n + {31'b0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/ibuff_wr_alloc.sv
// rtl/ibuff_wr_alloc.sv - prefix-popcount write allocator: compacts valid lanes onto consecutive entries from tail
module ibuff_wr_alloc #(
   parameter int WR_PORTS = ibuff_pkg::WR_PORTS,
   parameter int INDEX    = ibuff_pkg::INDEX
) (
   input  logic [WR_PORTS-1:0]       valid,
   input  logic                      en,
   input  logic [INDEX-1:0]          tail,
   output logic [WR_PORTS-1:0]       we,
   output logic [WR_PORTS*INDEX-1:0] addr,
   output logic [INDEX:0]            n_wr
);
   import ibuff_pkg::*;

   // Each lane's address depends only on the lower valid lanes, so an invalid lane leaves no hole.
   always_comb begin
      logic [INDEX-1:0] rank;
      addr = '0;
      rank = '0;
      for (int i = 0; i < WR_PORTS; i++) begin
         addr[i*INDEX +: INDEX] = tail + rank;
         rank = rank + INDEX'(valid[i]);
      end
   end

   assign we   = valid & {WR_PORTS{en}};
   assign n_wr = (INDEX+1)'(popcount(64'(we)));

endmodule

// File: rtl/ibuff_ctrl.sv
// rtl/ibuff_ctrl.sv - circular-queue controller for the instruction buffer RAM (pointers, occupancy, handshakes)
module ibuff_ctrl #(
   parameter int DEPTH    = ibuff_pkg::DEPTH,
   parameter int INDEX    = ibuff_pkg::INDEX,
   parameter int WR_PORTS = ibuff_pkg::WR_PORTS,
   parameter int RD_PORTS = ibuff_pkg::RD_PORTS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush_i,
   input  logic [WR_PORTS-1:0]       wrValid_i,
   output logic [WR_PORTS-1:0]       we_o,
   output logic [WR_PORTS*INDEX-1:0] addrWr_o,
   input  logic                      dispatchReady_i,
   output logic                      bundleValid_o,
   output logic [RD_PORTS*INDEX-1:0] addrRd_o,
   output logic                      stall_o,
   output logic [INDEX:0]            count_o
);
   import ibuff_pkg::*;

   localparam logic [INDEX:0]   DEPTH_C = (INDEX+1)'(DEPTH);
   localparam logic [INDEX:0]   WR_C    = (INDEX+1)'(WR_PORTS);
   localparam logic [INDEX:0]   RD_C    = (INDEX+1)'(RD_PORTS);
   localparam logic [INDEX-1:0] RD_STEP = INDEX'(RD_PORTS);

   logic [INDEX-1:0] head;
   logic [INDEX-1:0] tail;
   logic [INDEX:0]   count;
   logic [INDEX:0]   n_wr;
   logic             wr_en;
   logic             fire;

   // Stall looks only at registered occupancy; a same-cycle dispatch is not credited.
   assign stall_o       = (DEPTH_C - count) < WR_C;
   assign wr_en         = reset & ~stall_o & ~flush_i;
   assign bundleValid_o = (count >= RD_C) & ~flush_i;
   assign fire          = bundleValid_o & dispatchReady_i;
   assign count_o       = count;

   ibuff_wr_alloc #(
      .WR_PORTS(WR_PORTS),
      .INDEX   (INDEX)
   ) u_wr_alloc (
      .valid(wrValid_i),
      .en   (wr_en),
      .tail (tail),
      .we   (we_o),
      .addr (addrWr_o),
      .n_wr (n_wr)
   );

   always_comb begin
      addrRd_o = '0;
      for (int k = 0; k < RD_PORTS; k++) begin
         addrRd_o[k*INDEX +: INDEX] = head + INDEX'(k);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         tail  <= tail + n_wr[INDEX-1:0];
         if (fire) begin
            head <= head + RD_STEP;
         end
         count <= count + n_wr - (fire ? RD_C : '0);
      end
   end

   // count's low bits must track the pointer distance; count==DEPTH aliases to tail==head.
   logic [INDEX-1:0] occ;
   assign occ = tail - head;

   a_count_max: assert property (@(posedge clk) disable iff (!reset) count <= DEPTH_C);
   a_count_ptr: assert property (@(posedge clk) disable iff (!reset) occ == count[INDEX-1:0]);

endmodule

// File: tb/tb_ibuff_ctrl.sv
// tb/tb_ibuff_ctrl.sv - table-driven self-checking bench for ibuff_ctrl
module tb_ibuff_ctrl;
   import ibuff_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic [7:0]  wr_valid;
   logic [7:0]  we;
   logic [39:0] addr_wr;
   logic        rdy;
   logic        bundle_valid;
   logic [19:0] addr_rd;
   logic        stall;
   ibuffCnt_t   count;

   int checks;
   int failures;

   ibuff_ctrl dut (
      .clk            (clk),
      .reset          (reset_n),
      .flush_i        (flush),
      .wrValid_i      (wr_valid),
      .we_o           (we),
      .addrWr_o       (addr_wr),
      .dispatchReady_i(rdy),
      .bundleValid_o  (bundle_valid),
      .addrRd_o       (addr_rd),
      .stall_o        (stall),
      .count_o        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        flush;
      logic [7:0]  wr;
      logic        rdy;
      logic [7:0]  we;
      logic        stall;
      logic        bv;
      int          cnt;
      logic        aw_chk;
      logic [39:0] aw;
      int          head;
   } vec_t;

   vec_t vq[$];

   function automatic logic [39:0] pk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
      logic [39:0] r;
      r = {5'(a7), 5'(a6), 5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
      return r;
   endfunction

   function automatic logic [39:0] seq8(input int t);
      logic [39:0] r;
      for (int i = 0; i < 8; i++) r[i*5 +: 5] = 5'((t + i) % 32);
      return r;
   endfunction

   function automatic logic [19:0] seq4(input int h);
      logic [19:0] r;
      for (int i = 0; i < 4; i++) r[i*5 +: 5] = 5'((h + i) % 32);
      return r;
   endfunction

   task automatic add(input string n, input logic f, input logic [7:0] wr, input logic r,
                      input logic [7:0] w, input logic st, input logic bv, input int cnt,
                      input logic ac, input logic [39:0] aw, input int h);
      vec_t v;
      v.name = n; v.flush = f; v.wr = wr; v.rdy = r; v.we = w; v.stall = st; v.bv = bv;
      v.cnt = cnt; v.aw_chk = ac; v.aw = aw; v.head = h;
      vq.push_back(v);
   endtask

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string n);
      chk({n, ".count"}, 64'(count), 64'd0);
      chk({n, ".stall"}, 64'(stall), 64'd0);
      chk({n, ".bv"}, 64'(bundle_valid), 64'd0);
      chk({n, ".we"}, 64'(we), 64'd0);
      chk({n, ".addr_rd"}, 64'(addr_rd), 64'(seq4(0)));
      chk({n, ".addr_wr"}, 64'(addr_wr), 64'(seq8(0)));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      flush    = 1'b0;
      wr_valid = 8'hFF;
      rdy      = 1'b1;

      // name, flush, wr, rdy | we, stall, bv, count, aw_chk, addr_wr, head
      add("fill0",    0, 8'hFF, 0, 8'hFF, 0, 0,  0, 1, seq8(0),  0);
      add("fill1",    0, 8'hFF, 0, 8'hFF, 0, 1,  8, 1, seq8(8),  0);
      add("fill2",    0, 8'hFF, 0, 8'hFF, 0, 1, 16, 1, seq8(16), 0);
      add("fill3",    0, 8'hFF, 0, 8'hFF, 0, 1, 24, 1, seq8(24), 0);
      add("full",     0, 8'hFF, 0, 8'h00, 1, 1, 32, 1, seq8(0),  0);
      add("full_hold",0, 8'hFF, 0, 8'h00, 1, 1, 32, 0, '0,       0);
      add("drain",    0, 8'h00, 1, 8'h00, 1, 1, 32, 0, '0,       0);
      add("stall28",  0, 8'hFF, 0, 8'h00, 1, 1, 28, 0, '0,       4);
      add("flush28",  1, 8'hFF, 1, 8'h00, 1, 0, 28, 0, '0,       4);
      add("post_fl",  0, 8'h00, 0, 8'h00, 0, 0,  0, 1, '0,       0);
      add("to12a",    0, 8'hFF, 0, 8'hFF, 0, 0,  0, 1, seq8(0),  0);
      add("to12b",    0, 8'h0F, 0, 8'h0F, 0, 1,  8, 1, pk8(8,9,10,11,12,12,12,12), 0);
      add("flush12",  1, 8'hFF, 1, 8'h00, 0, 0, 12, 1, seq8(12), 0);
      add("flushed",  0, 8'h00, 0, 8'h00, 0, 0,  0, 1, '0,       0);
      add("w0",       0, 8'hFF, 1, 8'hFF, 0, 0,  0, 1, seq8(0),  0);
      add("w1",       0, 8'hFF, 1, 8'hFF, 0, 1,  8, 1, seq8(8),  0);
      add("w2",       0, 8'hFF, 1, 8'hFF, 0, 1, 12, 1, seq8(16), 4);
      add("w3",       0, 8'h0F, 1, 8'h0F, 0, 1, 16, 1, pk8(24,25,26,27,28,28,28,28), 8);
      add("w4",       0, 8'h00, 1, 8'h00, 0, 1, 16, 0, '0,      12);
      add("w5",       0, 8'h00, 1, 8'h00, 0, 1, 12, 0, '0,      16);
      add("w6",       0, 8'h00, 1, 8'h00, 0, 1,  8, 0, '0,      20);
      add("w7",       0, 8'h00, 1, 8'h00, 0, 1,  4, 0, '0,      24);
      add("wrap_wr",  0, 8'hFF, 0, 8'hFF, 0, 0,  0, 1, pk8(28,29,30,31,0,1,2,3), 28);
      add("wrap_rd0", 0, 8'h00, 1, 8'h00, 0, 1,  8, 0, '0,      28);
      add("wrap_rd1", 0, 8'h00, 1, 8'h00, 0, 1,  4, 0, '0,       0);
      add("c5a",      0, 8'h1F, 0, 8'h1F, 0, 0,  0, 1, pk8(4,5,6,7,8,9,9,9), 4);
      add("c5b",      0, 8'h0F, 1, 8'h0F, 0, 1,  5, 1, pk8(9,10,11,12,13,13,13,13), 4);
      add("c5c",      0, 8'h00, 0, 8'h00, 0, 1,  5, 1, pk8(13,13,13,13,13,13,13,13), 8);
      add("c3a",      0, 8'h00, 1, 8'h00, 0, 1,  5, 0, '0,       8);
      add("c3b",      0, 8'h03, 0, 8'h03, 0, 0,  1, 1, pk8(13,14,15,15,15,15,15,15), 12);
      add("c3c",      0, 8'h00, 1, 8'h00, 0, 0,  3, 0, '0,      12);
      add("c3d",      0, 8'h01, 1, 8'h01, 0, 0,  3, 1, pk8(15,16,16,16,16,16,16,16), 12);
      add("c3e",      0, 8'h00, 0, 8'h00, 0, 1,  4, 0, '0,      12);
      add("nc_flush", 1, 8'h00, 0, 8'h00, 0, 0,  4, 0, '0,      12);
      add("nc_pre",   0, 8'h07, 0, 8'h07, 0, 0,  0, 1, pk8(0,1,2,3,3,3,3,3), 0);
      add("nc",       0, 8'hA5, 0, 8'hA5, 0, 0,  3, 1, pk8(3,4,4,5,5,5,6,6), 0);
      add("nc_after", 0, 8'h00, 0, 8'h00, 0, 1,  7, 1, pk8(7,7,7,7,7,7,7,7), 0);

      repeat (2) @(negedge clk);
      #1;
      chk_reset_vals("reset_hold");

      @(negedge clk);
      reset_n  = 1'b1;
      wr_valid = 8'h00;
      rdy      = 1'b0;
      #1;
      chk("post_reset.count", 64'(count), 64'd0);

      foreach (vq[i]) begin
         @(negedge clk);
         flush    = vq[i].flush;
         wr_valid = vq[i].wr;
         rdy      = vq[i].rdy;
         #1;
         chk({vq[i].name, ".we"},    64'(we),           64'(vq[i].we));
         chk({vq[i].name, ".stall"}, 64'(stall),        64'(vq[i].stall));
         chk({vq[i].name, ".bv"},    64'(bundle_valid), 64'(vq[i].bv));
         chk({vq[i].name, ".count"}, 64'(count),        64'(vq[i].cnt));
         chk({vq[i].name, ".addr_rd"}, 64'(addr_rd),    64'(seq4(vq[i].head)));
         if (vq[i].aw_chk) chk({vq[i].name, ".addr_wr"}, 64'(addr_wr), 64'(vq[i].aw));
      end

      // Reset asserted mid-stream with active writes and a ready dispatch.
      @(negedge clk);
      flush    = 1'b0;
      wr_valid = 8'hFF;
      rdy      = 1'b1;
      #1;
      chk("mid.pre_count", 64'(count), 64'd7);
      #1;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("mid_reset");
      @(posedge clk);
      #2;
      chk_reset_vals("mid_reset_edge");
      @(negedge clk);
      reset_n  = 1'b1;
      wr_valid = 8'h00;
      rdy      = 1'b0;
      #1;
      chk("mid_release.count", 64'(count), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
